// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//   Shared constants and the hex-to-segment decoder for the seven-segment
//   scan driver.
//
//   Contents:
//     MAX_DIGITS  largest digit count the scan driver is meant to handle
//     SEG_OFF     active-low segment pattern with every segment dark
//     hex_to_seg  4-bit nibble -> 7-bit active-low pattern (bit0 = a .. bit6 = g)
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  localparam int         MAX_DIGITS = 8;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  // Common-anode digits: a 0 lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
//   Slot prescaler and digit index for the seven-segment scan driver.
//   The prescaler counts 0..REFRESH_DIV-1 inside each digit slot; at terminal
//   count the digit index advances and wraps from NUM_DIGITS-1 to 0. While
//   enable is low both counters are held at 0.
//
//   Parameters: NUM_DIGITS, REFRESH_DIV (>= GUARD+2), GUARD
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     enable       scan enable
//     idx          current digit index
//     guard        prescaler is inside the leading dark interval of the slot
//     frame_end    terminal count of the last digit (index is about to wrap)
//     scan_start   first enabled cycle after a disabled one
//   All outputs are combinational views of the current counter state; the
//   top level registers whatever it drives off-chip.
// -----------------------------------------------------------------------------
module scan_timer
  import seven_seg_pkg::*;
#(
  parameter int  NUM_DIGITS  = 4,
  parameter int  REFRESH_DIV = 50000,
  parameter int  GUARD       = 2,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [IDX_W-1:0] idx,
  output logic             guard,
  output logic             frame_end,
  output logic             scan_start
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             run_q, run_d;
  logic             slot_end;

  // NOTE: every signal assigned in always_comb gets a default on entry so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = '0;
    idx_d    = '0;
    run_d    = enable;
    if (enable) begin
      if (slot_end) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

  assign idx        = idx_q;
  assign guard      = (int'(cnt_q) < GUARD);
  assign frame_end  = enable && slot_end && (idx_q == IDX_LAST);
  assign scan_start = enable && !run_q;

endmodule

// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
//   New values are captured into a pending set on load and copied to the
//   active (displayed) set only at frame start, so a frame never mixes old and
//   new digits. Each digit slot opens with GUARD dark cycles against ghosting.
//
//   Optional feature: define SEVEN_SEG_LZ_BLANK_EN for leading-zero suppression
//   on the active set (digit 0 is never suppressed; a suppressed digit still
//   shows its decimal point).
//
//   Parameters: NUM_DIGITS (1..8), REFRESH_DIV (>= GUARD+2), GUARD
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     value        hex nibbles, nibble i -> digit i (digit 0 rightmost)
//     dp_in        decimal point request per digit, 1 = lit
//     blank        force digit dark, 1 = blank
//     load         capture value/dp_in/blank into the pending set
//     enable       scan enable
//     seg_n        segments a..g, active-low (bit0 = a)
//     dp_n         decimal point, active-low
//     an_n         digit anodes, active-low, at most one low
//     frame_done   one-cycle pulse when the last digit's slot ends
//   All outputs are registered.
// -----------------------------------------------------------------------------
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [IDX_W-1:0] idx;
  logic             guard;
  logic             frame_end;
  logic             scan_start;
  logic             frame_start;

  scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD      (GUARD)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .idx       (idx),
    .guard     (guard),
    .frame_end (frame_end),
    .scan_start(scan_start)
  );

  assign frame_start = scan_start || frame_end;

  // ---------------------------------------------------------------------------
  // Pending / active register sets
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    load_pend_q, load_pend_d;
  logic [4*NUM_DIGITS-1:0] act_value_q, act_value_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;

  // The copy reads the pending set as it was before this edge; a load on the
  // same cycle lands in pending and re-arms the flag for the next frame.
  always_comb begin
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    load_pend_d  = load_pend_q;
    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (frame_start && load_pend_q) begin
      act_value_d = pend_value_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      load_pend_d = 1'b0;
    end
    if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp_in;
      pend_blank_d = blank;
      load_pend_d  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Displayed set. On the first enabled cycle the copy is happening at this
  // very edge, so look through to the post-copy value; otherwise show the
  // registered active set so a frame-end copy never tears the last digit.
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic [NUM_DIGITS-1:0]   lz_mask;

  assign disp_value = scan_start ? act_value_d : act_value_q;
  assign disp_dp    = scan_start ? act_dp_d    : act_dp_q;
  assign disp_blank = scan_start ? act_blank_d : act_blank_q;

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Walk from the most significant digit down; zeros stay suppressed until the
  // first nonzero nibble. Digit 0 is left out so a zero value still shows "0".
  always_comb begin
    logic nonzero_seen;
    nonzero_seen = 1'b0;
    lz_mask      = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_value[4*i +: 4] != 4'h0) nonzero_seen = 1'b1;
      lz_mask[i] = !nonzero_seen;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_lz;
  logic                  lit;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  always_comb begin
    digit_sel = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        digit_sel[i] = 1'b1;
        cur_nib      = disp_value[4*i +: 4];
        cur_dp       = disp_dp[i];
        cur_blank    = disp_blank[i];
        cur_lz       = lz_mask[i];
      end
    end

    lit          = enable && !guard;
    an_n_d       = lit ? ~digit_sel : '1;
    seg_n_d      = SEG_OFF;
    dp_n_d       = 1'b1;
    frame_done_d = frame_end;
    // A blanked or suppressed digit keeps its anode driven but shows no
    // segments; only the blank bit also kills the decimal point.
    if (lit && !cur_blank) begin
      dp_n_d = !cur_dp;
      if (!cur_lz) seg_n_d = hex_to_seg(cur_nib);
    end
  end

  // NOTE: the pending and active sets are ordinary registers, not a RAM, so
  // they are reset like any other state and the display powers up as zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      load_pend_q  <= 1'b0;
      act_value_q  <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      seg_n_q      <= SEG_OFF;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      load_pend_q  <= load_pend_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//   Bench for seven_seg_scan with NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, so a
//   slot is one dark cycle plus three lit cycles and a frame is 16 cycles.
//   Expected per-cycle outputs are queued when a frame is scheduled and popped
//   one per clock. Build with SEVEN_SEG_LZ_BLANK_EN defined to cover the
//   leading-zero suppression variant.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int GRD = 1;

`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] value  = '0;
  logic [3:0]  dp_in  = '0;
  logic [3:0]  blank  = '0;
  logic        load   = 1'b0;
  logic        enable = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  seven_seg_scan #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(DIV),
    .GUARD      (GRD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .dp_in     (dp_in),
    .blank     (blank),
    .load      (load),
    .enable    (enable),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  // One displayed frame: the inputs that produce it and, per digit, the
  // segment pattern (digit i at segs[7*i +: 7]) and dp_n it must show.
  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [27:0] segs;
    logic [3:0]  dpn;
  } frame_vec_t;

  localparam obs_t IDLE = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};

  obs_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  string      phase  = "init";

  frame_vec_t v1234, vabcd, v9876, v5e0f, v0050, v0000;
  frame_vec_t dec_tab[16];
  logic [6:0] seg_ref[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) sb_q.push_back(IDLE);
  endtask

  // Queue the first ncyc cycles of a frame showing fv.
  task automatic push_frame(input frame_vec_t fv, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      int   d;
      obs_t o;
      d = k / 4;
      if (k % 4 == 0) begin
        o = IDLE;
      end else begin
        o.an  = ~(4'b0001 << d);
        o.seg = fv.segs[7*d +: 7];
        o.dp  = fv.dpn[d];
        o.fd  = (k == 15);
      end
      sb_q.push_back(o);
    end
  endtask

  task automatic apply_load(input frame_vec_t fv);
    value = fv.value;
    dp_in = fv.dp;
    blank = fv.blank;
    load  = 1'b1;
  endtask

  task automatic step();
    obs_t got_o;
    obs_t exp_o;
    @(posedge clk);
    #1;
    got_o = '{an: an_n, seg: seg_n, dp: dp_n, fd: frame_done};
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0h", phase, got_o);
    end else begin
      exp_o = sb_q.pop_front();
      check(phase, got_o, exp_o);
    end
  endtask

  initial begin
    seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    v1234 = '{16'h1234, 4'h0, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
    vabcd = '{16'hABCD, 4'h0, 4'h0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF};
    v9876 = '{16'h9876, 4'b0010, 4'b0100, {7'h10, 7'h7F, 7'h78, 7'h02}, 4'b1101};
    v5e0f = '{16'h5E0F, 4'h0, 4'h0, {7'h12, 7'h06, 7'h40, 7'h0E}, 4'hF};
    v0050 = '{16'h0050, 4'h0, 4'h0, {LZ_SEG, LZ_SEG, 7'h12, 7'h40}, 4'hF};
    v0000 = '{16'h0000, 4'h0, 4'h0, {LZ_SEG, LZ_SEG, LZ_SEG, 7'h40}, 4'hF};

    for (int r = 0; r < 16; r++) begin
      logic [3:0] nib;
      nib              = 4'(r);
      dec_tab[r].value = {4{nib}};
      dec_tab[r].dp    = nib ^ 4'b0101;
      dec_tab[r].blank = 4'h0;
      dec_tab[r].segs  = (r == 0) ? {LZ_SEG, LZ_SEG, LZ_SEG, 7'h40} : {4{seg_ref[r]}};
      dec_tab[r].dpn   = ~(nib ^ 4'b0101);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_seg_n", 32'(seg_n), 32'h7F);
    check("reset_dp_n", 32'(dp_n), 32'h1);
    check("reset_an_n", 32'(an_n), 32'hF);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;

    // Load while disabled, then start scanning
    phase = "load_idle";
    apply_load(v1234);
    push_idle(1);
    step();
    load   = 1'b0;
    enable = 1'b1;

    phase = "frame_1234";
    push_frame(v1234, 16);
    repeat (16) step();

    // Mid-frame load: the running frame must stay tear-free
    phase = "midframe_load";
    push_frame(v1234, 16);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) apply_load(vabcd);
      else        load = 1'b0;
      step();
    end
    load = 1'b0;

    // Second load lands exactly on the frame-start cycle
    phase = "frame_abcd";
    push_frame(vabcd, 16);
    for (int i = 0; i < 16; i++) begin
      if (i == 8)       apply_load(v9876);
      else if (i == 15) apply_load(v5e0f);
      else              load = 1'b0;
      step();
    end
    load = 1'b0;

    phase = "copy_pre_load_pending";
    push_frame(v9876, 16);
    repeat (16) step();

    phase = "load_on_copy_deferred";
    push_frame(v5e0f, 16);
    repeat (16) step();

    // Decode table: each row loaded at the start of a frame shows one frame later
    for (int r = 0; r < 16; r++) begin
      phase = $sformatf("decode_row_%0d", r);
      if (r == 0) push_frame(v5e0f, 16);
      else        push_frame(dec_tab[r-1], 16);
      for (int i = 0; i < 16; i++) begin
        if (i == 0) apply_load(dec_tab[r]);
        else        load = 1'b0;
        step();
      end
    end
    load  = 1'b0;
    phase = "decode_row_15_shown";
    push_frame(dec_tab[15], 16);
    repeat (16) step();

    // Drop enable inside digit 2's slot, load while disabled, re-enable
    phase = "disable";
    push_frame(dec_tab[15], 9);
    repeat (9) step();
    enable = 1'b0;
    push_idle(3);
    step();
    apply_load(v0050);
    step();
    load = 1'b0;
    step();

    enable = 1'b1;
    phase  = "restart_0050";
    push_frame(v0050, 16);
    repeat (16) step();

    // Asynchronous reset mid-scan with a load outstanding
    phase = "pre_async_reset";
    push_frame(v0050, 6);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) apply_load(v1234);
      else        load = 1'b0;
      step();
    end
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_seg_n", 32'(seg_n), 32'h7F);
    check("async_rst_dp_n", 32'(dp_n), 32'h1);
    check("async_rst_an_n", 32'(an_n), 32'hF);
    check("async_rst_frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    phase = "after_reset_load_lost";
    push_frame(v0000, 16);
    repeat (16) step();

    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
